// File: rtl/mix_round_inverter_if.sv
// ---------------------------------------------------------------------------
// mix_round_inverter_if
// Handshake bundle between a producer of mixed 8x32 states, the round
// inverter, and the consumer of decoded states.
//   in_valid  / in_ready  : input handshake, in_data is the mixed state
//   out_valid / out_ready : output handshake, out_data is the decoded state
//   busy                  : inverse rounds in progress
// Word i of in_data/out_data occupies bits [32i+31:32i].
// ---------------------------------------------------------------------------
interface mix_round_inverter_if;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_data;
    logic         busy;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/mix_round_inverter.sv
// ---------------------------------------------------------------------------
// mix_round_inverter
// Undoes ROUNDS forward mixing rounds on an 8-word 32-bit state, one
// elementary word update per clock (24 steps per inverse round).
// Ports:
//   clk   : clock, all updates on posedge
//   rst_n : asynchronous active-low reset, clears state, words and counters
//   bus   : slave side of mix_round_inverter_if (in/out handshakes, busy)
// Latency: accept on cycle T -> out_valid on cycle T + 24*ROUNDS + 1.
// ---------------------------------------------------------------------------
module mix_round_inverter #(
    parameter int ROUNDS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mix_round_inverter_if.slave   bus
);

    if (ROUNDS < 1 || ROUNDS > 255) begin : g_bad_rounds
        $error("mix_round_inverter: ROUNDS must be in 1..255");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic [31:0]  r_words [8];
    logic [4:0]   r_step;
    logic [7:0]   r_round;

    logic         w_accept;
    logic         w_last_step;
    logic         w_in_ready;
    logic         w_out_valid;
    logic         w_busy;
    logic [2:0]   w_idx;
    logic [2:0]   w_i1;
    logic [2:0]   w_i2;
    logic [2:0]   w_i3;
    logic [2:0]   w_i4;
    logic [2:0]   w_i5;
    logic [31:0]  w_cur;
    logic [31:0]  w_new;
    logic [255:0] w_out;

    // Steps 0..7, 8..15, 16..23 each walk i = 7 down to 0, so the low three
    // step bits select the word and the top two bits select the phase.
    // Neighbour indices wrap mod 8 through 3-bit arithmetic.
    assign w_idx = 3'd7 - r_step[2:0];
    assign w_i1  = w_idx + 3'd1;
    assign w_i2  = w_idx + 3'd2;
    assign w_i3  = w_idx + 3'd3;
    assign w_i4  = w_idx + 3'd4;
    assign w_i5  = w_idx + 3'd5;

    always_comb begin
        w_cur = r_words[w_idx];
        case (r_step[4:3])
            2'd0:    w_new = w_cur + (r_words[w_i2] >> 17) - (r_words[w_i4] >> 12);
            2'd1:    w_new = w_cur ^ (r_words[w_i3] << 16);
            default: w_new = w_cur - r_words[w_i1] + r_words[w_i5];
        endcase
    end

    assign w_last_step = (r_step == 5'd23) && (r_round == 8'(ROUNDS - 1));
    assign w_accept    = (r_state == S_IDLE) && bus.in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_next = S_RUN;
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_last_step) w_next = S_DONE;
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                // Returning to IDLE only after the handshake keeps the next
                // accept at least one cycle behind the output transfer.
                if (bus.out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) r_words[i] <= '0;
            r_step  <= '0;
            r_round <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < 8; i++) r_words[i] <= bus.in_data[32*i +: 32];
            r_step  <= '0;
            r_round <= '0;
        end else if (r_state == S_RUN) begin
            r_words[w_idx] <= w_new;
            if (r_step == 5'd23) begin
                r_step  <= '0;
                r_round <= r_round + 8'd1;
            end else begin
                r_step  <= r_step + 5'd1;
            end
        end
    end

    always_comb begin
        w_out = '0;
        for (int i = 0; i < 8; i++) w_out[32*i +: 32] = r_words[i];
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.out_data  = w_out;

endmodule

// File: doc/mix_round_inverter.md
Name: mix_round_inverter

Overview:
- Iterative decoder that undoes the team's 8-word 32-bit mixing round, i.e. it is the inverse direction of the state mixer.
- Accepts a mixed 8x32 state, applies ROUNDS inverse rounds at one elementary step per clock, and returns the pre-mix state.
- Sits downstream of the mixer in round-trip checks and in descramble paths.

Parameters:
ROUNDS, 8, number of inverse rounds applied per transaction (legal range 1..255)

Ports:
clk  input  1  clock, all state updates on posedge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data holds a state to decode
in_ready  output  1  block can accept a state
in_data  input  256  mixed state; word i = in_data[32i+31:32i], i=0..7
out_valid  output  1  out_data holds the decoded state
out_ready  input  1  consumer accepts out_data
out_data  output  256  decoded state, same word packing as in_data
busy  output  1  high while inverse rounds are being computed

Behaviour:
- Forward round being inverted (all indices mod 8, all arithmetic mod 2^32, shifts logical, unsigned):
  - A, i=0..7: o[i] = o[i] + o[i+1] - o[i+5]
  - B, i=0..7: o[i] = o[i] ^ (o[i+3] << 16)
  - C, i=0..7: o[i] = o[i] - (o[i+2] >> 17) + (o[i+4] >> 12)
- One inverse round is 24 elementary steps, one per cycle, in this order:
  - C-inverse, i=7 down to 0: o[i] = o[i] + (o[i+2] >> 17) - (o[i+4] >> 12)
  - B-inverse, i=7 down to 0: o[i] = o[i] ^ (o[i+3] << 16)
  - A-inverse, i=7 down to 0: o[i] = o[i] - o[i+1] + o[i+5]
- Each step updates exactly one word. It reads the other words' current register values, which include updates made by earlier steps.
- State machine IDLE / RUN / DONE:
  - IDLE: in_ready=1. On in_valid: load 8 words from in_data, clear step counter (0..23) and round counter, go to RUN.
  - RUN: busy=1, in_ready=0. Execute step[step_cnt] each cycle. At step 23, increment the round counter. After the last step of round ROUNDS-1, go to DONE.
  - DONE: out_valid=1, out_data = register file. Hold until out_ready=1. On out_valid && out_ready go to IDLE.
  - out_data is driven from the register file at all times but is meaningful only while out_valid=1.
- Latency: an accept on cycle T gives out_valid=1 on cycle T + 24*ROUNDS + 1. The first RUN cycle is T+1.
- No overlap between transactions:
  - in_ready=0 in RUN and DONE.
  - A DONE handshake and a new accept never occur on the same cycle. The earliest next accept is the cycle after the output handshake.
- Backpressure: while out_ready=0 in DONE, out_data and out_valid are held stable indefinitely.
- in_valid while not in IDLE is ignored. in_data is sampled only on the accept cycle.
- Reset (any time, including mid-RUN or DONE), asynchronous:
  - state=IDLE, all words=0, counters=0.
  - out_valid=0, busy=0, in_ready=1 on deassertion.
  - A partial computation is discarded.
- Any ROUNDS value outside 1..255 is an elaboration error.

Test Plan:
- Zero state, ROUNDS=8: in_data=0 accepted at T -> out_valid rises exactly at T+193, out_data=0, busy high for cycles T+1..T+192.
- Round-trip, ROUNDS=8: seeds o[i]=i (0..7) run through 8 forward rounds of the bench model, then fed in -> out_data words equal 0,1,...,7. Repeat with 100 random seeds; every output matches its seed.
- Single word, ROUNDS=1: forward image of o[0]=32'h0001_0000 (others 0) -> out_data word0=32'h0001_0000, all others 0, out_valid at T+25.
- Backpressure: hold out_ready=0 for 50 cycles in DONE -> out_valid stays 1, out_data unchanged, in_ready=0 throughout; out_ready=1 -> IDLE next cycle, in_ready=1.
- Busy-ignore: pulse in_valid with new data during RUN -> result still equals the first transaction's expected value.
- Reset mid-operation: assert rst_n=0 at step 50 of a run -> out_valid=0, busy=0, all words 0 immediately. After release, in_ready=1 and a fresh zero-state transaction completes with normal latency.
